// File: rtl/alpha_accum_if.sv
// Limb stream bundle for alpha_accum: operand input channel, sum output channel and busy flag.
// The `sub` signal exists only when ALPHA_ACC_SUB_EN is defined.
interface alpha_accum_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] carry_in;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             busy;
`ifdef ALPHA_ACC_SUB_EN
  logic             sub;

  modport master (
    output carry_in, in_valid, in_a, in_b, in_last, out_ready, sub,
    input  in_ready, out_valid, out_data, out_last, busy
  );
  modport slave (
    input  carry_in, in_valid, in_a, in_b, in_last, out_ready, sub,
    output in_ready, out_valid, out_data, out_last, busy
  );
`else
  modport master (
    output carry_in, in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );
  modport slave (
    input  carry_in, in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );
`endif
endinterface

// File: rtl/alpha_accum.sv
// Streaming multi-limb carry-propagate adder: one sum limb per operand limb, then a final-carry limb.
// Optional ALPHA_ACC_SUB_EN adds a per-frame subtract mode (a - b with borrow-mask final limb).
module alpha_accum #(
  parameter  int WIDTH     = 32,
  parameter  int NUM_WORDS = 8,
  localparam int CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  alpha_accum_if.slave  bus
);

  localparam logic [1:0]       S_IDLE   = 2'd0;
  localparam logic [1:0]       S_RUN    = 2'd1;
  localparam logic [1:0]       S_FLUSH  = 2'd2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [1:0]       c_q,        c_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q,  out_last_d;
  logic             busy_q,      busy_d;

  logic             slot_free_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             first_s;
  logic             eof_s;
  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH-1:0] cin_s;
  logic [WIDTH-1:0] flush_s;
  logic [WIDTH+1:0] sum_s;

`ifdef ALPHA_ACC_SUB_EN
  logic             sub_q, sub_d;
  logic             sub_eff_s;

  // Operand selection: subtract inverts b and seeds the carry with 1; final limb is a borrow mask.
  always_comb begin
    sub_eff_s = first_s ? bus.sub : sub_q;
    b_eff_s   = sub_eff_s ? ~bus.in_b : bus.in_b;
    if (first_s) begin
      cin_s = bus.sub ? {{(WIDTH-1){1'b0}}, 1'b1} : bus.carry_in;
    end else begin
      cin_s = {{(WIDTH-2){1'b0}}, c_q};
    end
    if (sub_q) begin
      flush_s = c_q[0] ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
    end else begin
      flush_s = {{(WIDTH-2){1'b0}}, c_q};
    end
  end
`else
  // Operand selection for the add-only build.
  always_comb begin
    b_eff_s = bus.in_b;
    cin_s   = first_s ? bus.carry_in : {{(WIDTH-2){1'b0}}, c_q};
    flush_s = {{(WIDTH-2){1'b0}}, c_q};
  end
`endif

  // Handshake decode and the limb adder; the slot frees in the same cycle it drains.
  always_comb begin
    slot_free_s = ~out_valid_q | bus.out_ready;
    in_ready_s  = (state_q != S_FLUSH) & slot_free_s;
    accept_s    = bus.in_valid & in_ready_s;
    first_s     = (state_q == S_IDLE);
    eof_s       = bus.in_last | (cnt_q == CNT_LAST);
    sum_s       = {2'b00, bus.in_a} + {2'b00, b_eff_s} + {2'b00, cin_s};
  end

  // Frame FSM and output register next-state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    c_d         = c_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
`ifdef ALPHA_ACC_SUB_EN
    sub_d       = sub_q;
`endif
    case (state_q)
      S_IDLE, S_RUN: begin
        if (accept_s) begin
          out_data_d  = sum_s[WIDTH-1:0];
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          c_d         = sum_s[WIDTH+1:WIDTH];
          busy_d      = 1'b1;
`ifdef ALPHA_ACC_SUB_EN
          sub_d       = sub_eff_s;
`endif
          if (eof_s) begin
            state_d = S_FLUSH;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            state_d = S_RUN;
            cnt_d   = cnt_q + CNT_ONE;
          end
        end else if (out_valid_q & bus.out_ready) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      S_FLUSH: begin
        if (out_last_q) begin
          if (bus.out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            busy_d      = 1'b0;
            c_d         = 2'b00;
            state_d     = S_IDLE;
          end else begin
            out_last_d  = out_last_q;
          end
        end else if (slot_free_s) begin
          out_data_d  = flush_s;
          out_valid_d = 1'b1;
          out_last_d  = 1'b1;
        end else begin
          out_last_d  = out_last_q;
        end
      end
      default: begin
        state_d     = S_IDLE;
        cnt_d       = {CNT_W{1'b0}};
        c_d         = 2'b00;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State registers; reset drops any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      c_q         <= 2'b00;
      out_data_q  <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ALPHA_ACC_SUB_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      c_q         <= c_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
`ifdef ALPHA_ACC_SUB_EN
      sub_q       <= sub_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_alpha_accum.sv
// Directed bench for alpha_accum (WIDTH=32, NUM_WORDS=4): table-driven frames plus
// hand-written backpressure, implicit-last hold-off and async-reset sequences.
module tb_alpha_accum;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alpha_accum_if #(.WIDTH(32)) bus ();

  alpha_accum #(.WIDTH(32), .NUM_WORDS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] cin;
    logic        last;
    logic [31:0] exp_sum;
    logic        has_flush;
    logic [31:0] exp_flush;
  } vec_t;

  vec_t        vecs[10];
  logic [32:0] got_q[$];
  logic [32:0] exp_q[$];

  logic        pend_v = 1'b0;
  logic [32:0] pend_w = 33'h0;

  // Output monitor: latch the handshake well before the edge, commit it on the edge.
  always begin
    @(negedge clk);
    #2;
    pend_v = bus.out_valid & bus.out_ready;
    pend_w = {bus.out_last, bus.out_data};
  end

  always @(posedge clk) begin
    if (pend_v && !rst) got_q.push_back(pend_w);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] cin, input logic last);
    bit done;
    done          = 1'b0;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.carry_in  = cin;
    bus.in_last   = last;
    bus.in_valid  = 1'b1;
    for (int t = 0; t < 40 && !done; t++) begin
      #1;
      if (bus.in_ready) begin
        @(posedge clk);
        done = 1'b1;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("send_accept", {63'h0, done}, 64'h1);
  endtask

  task automatic push_exp(input logic last, input logic [31:0] data);
    exp_q.push_back({last, data});
  endtask

  task automatic compare_q(input string name);
    repeat (4) @(negedge clk);
    chk({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_limb%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 32'h0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 32'h00000007, 1'b1, 32'h00000000, 1'b1, 32'h00000001};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFD, 1'b1, 32'h00000002};
    vecs[3] = '{32'h12345678, 32'h87654321, 32'h00000005, 1'b0, 32'h9999999E, 1'b0, 32'h0};
    vecs[4] = '{32'h80000000, 32'h80000000, 32'h00000009, 1'b0, 32'h00000000, 1'b0, 32'h0};
    vecs[5] = '{32'h7FFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 32'h80000000, 1'b1, 32'h00000000};
    vecs[6] = '{32'h00000001, 32'h00000000, 32'h00000000, 1'b0, 32'h00000001, 1'b0, 32'h0};
    vecs[7] = '{32'h00000001, 32'h00000000, 32'h00000000, 1'b0, 32'h00000001, 1'b0, 32'h0};
    vecs[8] = '{32'h00000001, 32'h00000000, 32'h00000000, 1'b0, 32'h00000001, 1'b0, 32'h0};
    vecs[9] = '{32'h00000001, 32'h00000000, 32'h00000000, 1'b0, 32'h00000001, 1'b1, 32'h00000000};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = 32'h0;
    bus.in_b      = 32'h0;
    bus.in_last   = 1'b0;
    bus.carry_in  = 32'h0;
    bus.out_ready = 1'b1;
`ifdef ALPHA_ACC_SUB_EN
    bus.sub       = 1'b0;
`endif

    @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_out_last",  64'(bus.out_last),  64'h0);
    chk("rst_out_data",  64'(bus.out_data),  64'h0);
    chk("rst_busy",      64'(bus.busy),      64'h0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'h1);
    @(negedge clk);
    rst = 1'b0;

    // in_last without in_valid in IDLE must do nothing
    bus.in_last = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("idle_last_busy",      64'(bus.busy),      64'h0);
    chk("idle_last_out_valid", 64'(bus.out_valid), 64'h0);
    bus.in_last = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].last);
      push_exp(1'b0, vecs[i].exp_sum);
      if (vecs[i].has_flush) push_exp(1'b1, vecs[i].exp_flush);
    end
    // 5th limb right after the implicit last: held off until the flush limb drains
    bus.in_a     = 32'h2;
    bus.in_b     = 32'h3;
    bus.carry_in = 32'h0;
    bus.in_last  = 1'b1;
    bus.in_valid = 1'b1;
    #1;
    chk("implicit_last_holdoff", 64'(bus.in_ready), 64'h0);
    chk("implicit_last_busy",    64'(bus.busy),     64'h1);
    @(negedge clk);
    send(32'h2, 32'h3, 32'h0, 1'b1);
    push_exp(1'b0, 32'h00000005);
    push_exp(1'b1, 32'h00000000);
    compare_q("table");

    // Backpressure: stall the output for 3 cycles with the next limb pending
    send(32'h10, 32'h20, 32'h0, 1'b0);
    bus.out_ready = 1'b0;
    bus.in_a      = 32'hFFFFFFF0;
    bus.in_b      = 32'h20;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_data_%0d", k),     64'(bus.out_data),  64'h30);
      chk($sformatf("bp_valid_%0d", k),    64'(bus.out_valid), 64'h1);
      chk($sformatf("bp_in_ready_%0d", k), 64'(bus.in_ready),  64'h0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    send(32'hFFFFFFF0, 32'h20, 32'h0, 1'b0);
    send(32'h1, 32'h1, 32'h0, 1'b1);
    push_exp(1'b0, 32'h00000030);
    push_exp(1'b0, 32'h00000010);
    push_exp(1'b0, 32'h00000003);
    push_exp(1'b1, 32'h00000000);
    compare_q("backpressure");

    // Async reset two limbs into a three-limb frame, then a clean frame
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h2, 1'b0);
    send(32'hFFFFFFFF, 32'h1, 32'h0, 1'b0);
    #1;
    chk("mid_frame_busy", 64'(bus.busy), 64'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("arst_busy",      64'(bus.busy),      64'h0);
    chk("arst_out_last",  64'(bus.out_last),  64'h0);
    @(negedge clk);
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
    send(32'h5, 32'h6, 32'h0, 1'b1);
    push_exp(1'b0, 32'h0000000B);
    push_exp(1'b1, 32'h00000000);
    compare_q("post_reset");

`ifdef ALPHA_ACC_SUB_EN
    bus.sub = 1'b1;
    send(32'h0, 32'h1, 32'h5, 1'b0);
    send(32'h0, 32'h0, 32'h0, 1'b1);
    bus.sub = 1'b0;
    push_exp(1'b0, 32'hFFFFFFFF);
    push_exp(1'b0, 32'hFFFFFFFF);
    push_exp(1'b1, 32'hFFFFFFFF);
    compare_q("sub_borrow");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
